// File: rtl/seg7_pkg.sv
// ==== seg7_pkg: scan-controller state encoding and hex glyph table for seven-segment digits.
// ==== Rev 1.0
`default_nettype none

package seg7_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Segment order is {g,f,e,d,c,b,a}, active-high.
  function automatic logic [6:0] seg7_glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0: g = 7'h3F;
      4'h1: g = 7'h06;
      4'h2: g = 7'h5B;
      4'h3: g = 7'h4F;
      4'h4: g = 7'h66;
      4'h5: g = 7'h6D;
      4'h6: g = 7'h7D;
      4'h7: g = 7'h07;
      4'h8: g = 7'h7F;
      4'h9: g = 7'h6F;
      4'hA: g = 7'h77;
      4'hB: g = 7'h7C;
      4'hC: g = 7'h39;
      4'hD: g = 7'h5E;
      4'hE: g = 7'h79;
      default: g = 7'h71;
    endcase
    return g;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seg7_decoder.sv
// ==== seg7_decoder: combinational nibble to seven-segment glyph.
// ==== Rev 1.0
`default_nettype none

module seg7_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = seg7_glyph(nibble);

endmodule

`default_nettype wire

// File: rtl/seg7_scan_ctrl.sv
// ==== seg7_scan_ctrl: blanked, double-buffered multiplexed 7-segment scanner.
// ==== Rev 1.0 -- optional LEADING_ZERO_BLANK_EN suppresses leading zero digits.
`default_nettype none

module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int PRESCALE       = 1000,
  parameter int BLANK_CYCLES   = 16,
  parameter int SEG_ACTIVE_LOW = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ena,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [4*NUM_DIGITS-1:0] wr_data,
  input  logic [NUM_DIGITS-1:0]   wr_dp,
  output logic [6:0]              segments,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_done
);

  localparam int IDXW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNTW = $clog2(PRESCALE);
  localparam logic [CNTW-1:0] BLANK_LAST = CNTW'(BLANK_CYCLES - 1);
  localparam logic [CNTW-1:0] SLOT_LAST  = CNTW'(PRESCALE - 1);
  localparam logic [IDXW-1:0] IDX_LAST   = IDXW'(NUM_DIGITS - 1);
  localparam logic            POL        = (SEG_ACTIVE_LOW != 0);

  state_t                  state, state_nx;
  logic [IDXW-1:0]         idx, idx_nx;
  logic [CNTW-1:0]         cnt, cnt_nx;
  logic [4*NUM_DIGITS-1:0] active_data, shadow_data;
  logic [NUM_DIGITS-1:0]   active_dp, shadow_dp;
  logic                    pending;
  logic                    xfer, boundary, commit;
  logic [3:0]              nibble;
  logic [6:0]              glyph, seg_nx;
  logic                    dp_nx, digit_dark;
  logic [NUM_DIGITS-1:0]   en_nx;

  assign wr_ready = !pending;
  assign xfer     = wr_valid && !pending;
  assign boundary = ena && (state == SHOW) && (cnt == SLOT_LAST) && (idx == IDX_LAST);
  // A write landing on the boundary cycle bypasses the shadow straight into active.
  assign commit   = (boundary && (pending || xfer)) || ((state == IDLE) && pending);

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    cnt_nx   = cnt;
    if (!ena) begin
      state_nx = IDLE;
      idx_nx   = '0;
      cnt_nx   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nx = BLANK;
          idx_nx   = '0;
          cnt_nx   = '0;
        end
        BLANK: begin
          cnt_nx = cnt + 1'b1;
          if (cnt == BLANK_LAST) state_nx = SHOW;
        end
        SHOW: begin
          if (cnt == SLOT_LAST) begin
            state_nx = BLANK;
            cnt_nx   = '0;
            idx_nx   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        default: begin
          state_nx = IDLE;
          idx_nx   = '0;
          cnt_nx   = '0;
        end
      endcase
    end
  end

  always_comb begin
    nibble     = '0;
    digit_dark = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_nx == IDXW'(i)) nibble = active_data[4*i +: 4];
    end
`ifdef LEADING_ZERO_BLANK_EN
    digit_dark = (idx_nx != '0) && ((active_data >> (4 * idx_nx)) == '0);
`endif
  end

  seg7_decoder u_dec (
    .nibble (nibble),
    .seg    (glyph)
  );

  // Outputs are computed from the next state so they change on the same edge.
  always_comb begin
    seg_nx = SEG_BLANK;
    dp_nx  = 1'b0;
    en_nx  = '0;
    if (state_nx == SHOW) begin
      en_nx  = NUM_DIGITS'(1) << idx_nx;
      dp_nx  = active_dp[idx_nx];
      seg_nx = digit_dark ? SEG_BLANK : glyph;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      cnt         <= '0;
      active_data <= '0;
      active_dp   <= '0;
      shadow_data <= '0;
      shadow_dp   <= '0;
      pending     <= 1'b0;
      segments    <= {7{POL}};
      dp          <= POL;
      digit_en    <= {NUM_DIGITS{POL}};
      frame_done  <= 1'b0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
      cnt   <= cnt_nx;
      if (xfer) begin
        shadow_data <= wr_data;
        shadow_dp   <= wr_dp;
      end
      if (commit) begin
        active_data <= pending ? shadow_data : wr_data;
        active_dp   <= pending ? shadow_dp : wr_dp;
        pending     <= 1'b0;
      end else if (xfer) begin
        pending <= 1'b1;
      end
      segments   <= seg_nx ^ {7{POL}};
      dp         <= dp_nx ^ POL;
      digit_en   <= en_nx ^ {NUM_DIGITS{POL}};
      frame_done <= boundary;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan_ctrl.sv
// ==== tb_seg7_scan_ctrl: randomized and directed checks of seg7_scan_ctrl against a frame-time model.
// ==== Rev 1.0
`default_nettype none

module tb_seg7_scan_ctrl;

  logic        clk;
  logic        rst_n;
  logic        ena;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] wr_data;
  logic [3:0]  wr_dp;
  logic [6:0]  segments;
  logic        dp;
  logic [3:0]  digit_en;
  logic        frame_done;

  int compared = 0;
  int mismatched = 0;

  // Model: time since scanning started, plus the shadow/active data registers.
  bit          running;
  int          t;
  logic [15:0] m_active, m_shadow;
  logic [3:0]  m_adp, m_sdp;
  bit          m_pend;
  bit          m_fd;

  logic [6:0] glyph_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  seg7_scan_ctrl #(
    .NUM_DIGITS     (4),
    .PRESCALE       (8),
    .BLANK_CYCLES   (2),
    .SEG_ACTIVE_LOW (0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_data    (wr_data),
    .wr_dp      (wr_dp),
    .segments   (segments),
    .dp         (dp),
    .digit_en   (digit_en),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h (t=%0d)", tag, obs, exp, t);
    end
  endtask

  task automatic model_reset();
    running  = 0;
    t        = 0;
    m_active = '0;
    m_shadow = '0;
    m_adp    = '0;
    m_sdp    = '0;
    m_pend   = 0;
    m_fd     = 0;
  endtask

  task automatic model_edge();
    bit idle_old, bnd, xf;
    idle_old = !running;
    bnd      = running && ena && (t % 32 == 31);
    xf       = wr_valid && !m_pend;
    m_fd     = bnd;
    if (bnd && (m_pend || xf)) begin
      m_active = m_pend ? m_shadow : wr_data;
      m_adp    = m_pend ? m_sdp : wr_dp;
      m_pend   = 0;
    end else if (idle_old && m_pend) begin
      m_active = m_shadow;
      m_adp    = m_sdp;
      m_pend   = 0;
    end else if (xf) begin
      m_shadow = wr_data;
      m_sdp    = wr_dp;
      m_pend   = 1;
    end
    if (!ena) begin
      running = 0;
      t       = 0;
    end else if (!running) begin
      running = 1;
      t       = 0;
    end else begin
      t++;
    end
  endtask

  task automatic check_all();
    logic [6:0] es;
    logic       ed;
    logic [3:0] ee;
    int pos, d;
    es = '0;
    ed = 1'b0;
    ee = '0;
    if (running) begin
      pos = t % 32;
      d   = pos / 8;
      if (pos % 8 >= 2) begin
        ee = 4'(1 << d);
        ed = m_adp[d];
        es = glyph_tbl[m_active[4*d +: 4]];
`ifdef LEADING_ZERO_BLANK_EN
        if (d != 0 && (m_active >> (4 * d)) == 16'h0) es = 7'h00;
`endif
      end
    end
    chk("segments", 32'(segments), 32'(es));
    chk("dp", 32'(dp), 32'(ed));
    chk("digit_en", 32'(digit_en), 32'(ee));
    chk("frame_done", 32'(frame_done), 32'(m_fd));
    chk("wr_ready", 32'(wr_ready), 32'(!m_pend));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic run_to(input int phase);
    for (int k = 0; k < 64 && !(running && (t % 32 == phase)); k++) step();
  endtask

  task automatic write_once(input logic [15:0] data, input logic [3:0] dpv);
    wr_valid = 1'b1;
    wr_data  = data;
    wr_dp    = dpv;
    step();
    wr_valid = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b1;
    ena      = 1'b0;
    wr_valid = 1'b0;
    wr_data  = '0;
    wr_dp    = '0;
    model_reset();
    #1 rst_n = 1'b0;
    #1 check_all();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ena   = 1'b1;

    // Free-running scan of zeros
    repeat (70) step();

    // Mid-frame write, displayed from the next frame on
    run_to(10);
    write_once(16'h12AF, 4'b0100);
    repeat (80) step();

    // Write on the boundary cycle, then a held write
    run_to(31);
    wr_valid = 1'b1;
    wr_data  = 16'h3C0D;
    wr_dp    = 4'b1001;
    step();
    wr_data  = 16'hBEEF;
    wr_dp    = 4'b0010;
    repeat (40) step();
    wr_valid = 1'b0;
    repeat (40) step();

    // ena dropped mid-SHOW of digit 2
    run_to(20);
    ena = 1'b0;
    step();
    ena = 1'b1;
    repeat (40) step();

    // Write while idle commits before scanning resumes
    ena = 1'b0;
    write_once(16'h4567, 4'b1000);
    repeat (3) step();
    ena = 1'b1;
    repeat (40) step();

    // Async reset between edges with a write pending
    run_to(5);
    write_once(16'h9999, 4'b1111);
    step();
    #1 rst_n = 1'b0;
    model_reset();
    #1 check_all();
    #1 rst_n = 1'b1;
    repeat (40) step();

    // Leading-zero patterns
    write_once(16'h0050, 4'b1100);
    repeat (70) step();
    write_once(16'h0000, 4'b0000);
    repeat (70) step();

    // Randomized traffic
    repeat (1500) begin
      ena      = ($urandom_range(0, 99) != 0);
      wr_valid = ($urandom_range(0, 3) == 0);
      wr_data  = 16'($urandom);
      wr_dp    = 4'($urandom);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
